// File: rtl/tomasula_types.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : tomasula_types                                                  |
// | Purpose  : Shared types for the Tomasulo back end. cdb_data is the opaque  |
// |            result payload carried on the common data bus.                  |
// | Contents : cdb_data (payload struct), CDB_N_SRC, CDB_N_SLOT                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package tomasula_types;

  typedef struct packed {
    logic [31:0] data;
  } cdb_data;

  localparam int CDB_N_SRC  = 12;
  localparam int CDB_N_SLOT = 8;

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_src_fifo                                                    |
// | Purpose  : Small per-source result FIFO in front of the CDB arbiter.       |
// |            flush (or rst) empties it at the clock edge; pushes and pops    |
// |            are ignored in a flush cycle.                                   |
// | Ports    : clk, rst        clock, synchronous active-high reset           |
// |            flush           discard all entries                            |
// |            push, din       write request and payload                      |
// |            pop             remove head entry                              |
// |            dout            head entry (valid when !empty)                 |
// |            empty, full     occupancy flags from registered count          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cdb_src_fifo
  import tomasula_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  cdb_data din,
  input  logic    pop,
  output cdb_data dout,
  output logic    empty,
  output logic    full
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  cdb_data         mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // Guards keep the FIFO self-consistent even if the caller misbehaves.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Payload storage carries no reset; the count alone qualifies it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cdb_arbiter                                                     |
// | Purpose  : Buffers completed results per source and packs up to N_SLOT of  |
// |            them per cycle into CDB slots 0..k-1.                           |
// | Config   : CDB_ARB_RR_EN defined   -> round-robin start pointer           |
// |            CDB_ARB_RR_EN undefined -> fixed priority, index 0 highest     |
// | Ports    : clk, rst      clock, synchronous active-high reset             |
// |            flush         drop all buffered results, no slot output        |
// |            src_valid     per-source result present                        |
// |            src_data      per-source payload                               |
// |            src_ready     per-source FIFO not full                         |
// |            ctl, enable   slot payloads and slot valids                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int N_SRC  = CDB_N_SRC,
  parameter int N_SLOT = CDB_N_SLOT,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  input  cdb_data [N_SRC-1:0]     src_data,
  output logic [N_SRC-1:0]        src_ready,
  output cdb_data [N_SLOT-1:0]    ctl,
  output logic [N_SLOT-1:0]       enable
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] empty;
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] grant;
  cdb_data          head [N_SRC];
  logic [PW-1:0]    start;
  int               key  [N_SRC];
  int               rank [N_SRC];

  assign src_ready = ~full;
  assign push      = src_valid & src_ready & {N_SRC{~flush}};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .din   (src_data[g]),
      .pop   (grant[g]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // key = distance from the start pointer in scan order; rank = number of
  // nonempty sources ahead in that order, which is also the slot a winner takes.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      key[i] = (i >= int'(start)) ? i - int'(start) : i + N_SRC - int'(start);
    end
    for (int i = 0; i < N_SRC; i++) begin
      rank[i] = 0;
      for (int j = 0; j < N_SRC; j++) begin
        if (!empty[j] && key[j] < key[i]) rank[i] = rank[i] + 1;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      grant[i] = !rst && !flush && !empty[i] && (rank[i] < N_SLOT);
    end
  end

  // Compaction: each slot picks the unique winner whose rank matches it.
  always_comb begin
    for (int s = 0; s < N_SLOT; s++) begin
      enable[s] = 1'b0;
      ctl[s]    = '0;
      for (int i = 0; i < N_SRC; i++) begin
        if (grant[i] && rank[i] == s) begin
          enable[s] = 1'b1;
          ctl[s]    = head[i];
        end
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_ptr;
  int            best_key;

  // The last winner in scan order is the one with the largest key.
  always_comb begin
    best_key = -1;
    next_ptr = rr_ptr;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i] && key[i] > best_key) begin
        best_key = key[i];
        next_ptr = (i == N_SRC - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= '0;
    else if (|grant)  rr_ptr <= next_ptr;
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cdb_arbiter                                                  |
// | Purpose  : Self-checking bench for cdb_arbiter. Two instances share the    |
// |            stimulus: 8 slots (dut0) and 1 slot (dut1). A queue-based       |
// |            reference model tracks each instance.                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cdb_arbiter;
  import tomasula_types::*;

  localparam int NS    = 12;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NS-1:0]     valid;
  cdb_data [NS-1:0]  din;
  logic [NS-1:0]     rdy0, rdy1;
  cdb_data [7:0]     ctl0;
  logic [7:0]        en0;
  cdb_data [0:0]     ctl1;
  logic [0:0]        en1;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(NS), .N_SLOT(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(valid), .src_data(din),
    .src_ready(rdy0), .ctl(ctl0), .enable(en0));

  cdb_arbiter #(.N_SRC(NS), .N_SLOT(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(valid), .src_data(din),
    .src_ready(rdy1), .ctl(ctl1), .enable(en1));

  int checks = 0;
  int errors = 0;

  // Reference model state: one queue per source per instance, plus start pointer.
  logic [31:0]   mq   [2][NS][$];
  int            mptr [2];
  logic [7:0]    xen  [2];
  logic [31:0]   xctl [2][8];
  int            xsrc [2][8];
  int            xgn  [2];
  logic [NS-1:0] xrdy [2];
  logic [31:0]   glog1[$];

  function automatic int nslot(input int m);
    return (m == 0) ? 8 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int n, p, s;
    for (int m = 0; m < 2; m++) begin
`ifdef CDB_ARB_RR_EN
      p = mptr[m];
`else
      p = 0;
`endif
      n = 0;
      xen[m] = '0;
      for (int k = 0; k < 8; k++) begin
        xctl[m][k] = '0;
        xsrc[m][k] = 0;
      end
      for (int i = 0; i < NS; i++) xrdy[m][i] = (mq[m][i].size() != DEPTH);
      if (!rst && !flush) begin
        for (int k = 0; k < NS; k++) begin
          s = (p + k) % NS;
          if (mq[m][s].size() > 0 && n < nslot(m)) begin
            xen[m][n]  = 1'b1;
            xctl[m][n] = mq[m][s][0];
            xsrc[m][n] = s;
            n++;
          end
        end
      end
      xgn[m] = n;
    end
  endtask

  task automatic model_update();
    logic [31:0] tmp;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < NS; i++) mq[m][i].delete();
        mptr[m] = 0;
      end else if (flush) begin
        for (int i = 0; i < NS; i++) mq[m][i].delete();
      end else begin
        for (int n = 0; n < xgn[m]; n++) tmp = mq[m][xsrc[m][n]].pop_front();
        for (int i = 0; i < NS; i++)
          if (valid[i] && xrdy[m][i]) mq[m][i].push_back(din[i].data);
        if (xgn[m] > 0) mptr[m] = (xsrc[m][xgn[m]-1] + 1) % NS;
      end
    end
  endtask

  // One cycle: compare both instances against the model, then clock.
  task automatic step();
    #1;
    model_eval();
    check("en0", {24'd0, en0}, {24'd0, xen[0]});
    for (int k = 0; k < 8; k++) check($sformatf("ctl0[%0d]", k), ctl0[k].data, xctl[0][k]);
    check("en1", {31'd0, en1[0]}, {31'd0, xen[1][0]});
    check("ctl1", ctl1[0].data, xctl[1][0]);
    if (!rst) begin
      check("rdy0", {20'd0, rdy0}, {20'd0, xrdy[0]});
      check("rdy1", {20'd0, rdy1}, {20'd0, xrdy[1]});
    end
    if (en1[0] === 1'b1) glog1.push_back(ctl1[0].data);
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic [11:0] valid;
    logic [31:0] base;
    logic [7:0]  en;
    logic [31:0] c0;
    logic        ck_rdy;
  } vec_t;

  vec_t tv [15];

  task automatic drive(input logic r, input logic f, input logic [NS-1:0] v, input logic [31:0] base);
    rst   = r;
    flush = f;
    valid = v;
    for (int i = 0; i < NS; i++) din[i].data = base + 32'(i);
  endtask

  int          fexp [6];
  int          pa, pb, seq5, bound;
  logic        seen_nr;
  logic [31:0] acc5 [$];
  logic [31:0] got5 [$];

  initial begin
    drive(1'b1, 1'b0, '0, 32'd0);
    @(posedge clk);
    #1;

    // rst, flush, valid, base, expected enable, expected ctl[0], check ready=FFF
    tv[0]  = '{1'b1, 1'b0, 12'hFFF, 32'h0000_0100, 8'h00, 32'h0,          1'b0};
    tv[1]  = '{1'b1, 1'b0, 12'hFFF, 32'h0000_0100, 8'h00, 32'h0,          1'b0};
    tv[2]  = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b1};
    tv[3]  = '{1'b0, 1'b0, 12'h008, 32'hDEAD_BEEC, 8'h00, 32'h0,          1'b1};
    tv[4]  = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h01, 32'hDEAD_BEEF,  1'b1};
    tv[5]  = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b1};
    tv[6]  = '{1'b1, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b0};
    tv[7]  = '{1'b0, 1'b0, 12'hFFF, 32'h0000_1000, 8'h00, 32'h0,          1'b1};
    tv[8]  = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'hFF, 32'h0000_1000,  1'b1};
    tv[9]  = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h0F, 32'h0000_1008,  1'b1};
    tv[10] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b1};
    tv[11] = '{1'b0, 1'b0, 12'h00F, 32'h0000_2000, 8'h00, 32'h0,          1'b1};
    tv[12] = '{1'b0, 1'b1, 12'h002, 32'h0000_2100, 8'h00, 32'h0,          1'b1};
    tv[13] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b1};
    tv[14] = '{1'b0, 1'b0, 12'h000, 32'h0000_0000, 8'h00, 32'h0,          1'b1};

    for (int r = 0; r < 15; r++) begin
      drive(tv[r].rst, tv[r].flush, tv[r].valid, tv[r].base);
      #1;
      check($sformatf("tv%0d_en", r), {24'd0, en0}, {24'd0, tv[r].en});
      check($sformatf("tv%0d_ctl0", r), ctl0[0].data, tv[r].c0);
      if (tv[r].ck_rdy) check($sformatf("tv%0d_rdy", r), {20'd0, rdy0}, 32'h0000_0FFF);
      step();
    end

    // Flush with several FIFOs holding two entries (1-slot instance backs up).
    drive(1'b1, 1'b0, '0, 32'd0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 12'h00F, 32'h0000_3000 + 32'(c * 16));
      step();
    end
    drive(1'b0, 1'b1, 12'h002, 32'h0000_3100);
    #1;
    check("flush_en1", {31'd0, en1[0]}, 32'd0);
    check("flush_en0", {24'd0, en0}, 32'd0);
    step();
    drive(1'b0, 1'b0, '0, 32'd0);
    #1;
    check("post_flush_en1", {31'd0, en1[0]}, 32'd0);
    check("post_flush_rdy1", {20'd0, rdy1}, 32'h0000_0FFF);
    check("post_flush_rdy0", {20'd0, rdy0}, 32'h0000_0FFF);
    step();

    // Fairness on the 1-slot instance: sources 0 and 9, three results each.
`ifdef CDB_ARB_RR_EN
    fexp = '{0, 9, 0, 9, 0, 9};
`else
    fexp = '{0, 0, 0, 9, 9, 9};
`endif
    drive(1'b1, 1'b0, '0, 32'd0);
    step();
    glog1.delete();
    pa = 3;
    pb = 3;
    bound = 0;
    while (glog1.size() < 6 && bound < 30) begin
      drive(1'b0, 1'b0, '0, 32'd0);
      valid[0] = (pa > 0);
      valid[9] = (pb > 0);
      din[0].data = {16'd0, 16'(3 - pa)};
      din[9].data = {16'd9, 16'(3 - pb)};
      step();
      if (valid[0] && xrdy[1][0]) pa--;
      if (valid[9] && xrdy[1][9]) pb--;
      bound++;
    end
    check("fair_count", 32'(glog1.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < glog1.size()) check($sformatf("fair_src%0d", k), {16'd0, glog1[k][31:16]}, 32'(fexp[k]));

    // Full FIFO on the 1-slot instance: source 0 always busy, source 5 pushes every cycle.
    drive(1'b1, 1'b0, '0, 32'd0);
    step();
    glog1.delete();
    seq5 = 0;
    seen_nr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      drive(1'b0, 1'b0, 12'h021, 32'd0);
      din[0].data = {16'd0, 16'(c)};
      din[5].data = {16'd5, 16'(seq5)};
      if (rdy1[5] === 1'b0) seen_nr = 1'b1;
      step();
      if (xrdy[1][5]) begin
        acc5.push_back(din[5].data);
        seq5++;
      end
    end
    drive(1'b0, 1'b0, '0, 32'd0);
    for (int c = 0; c < 30; c++) step();
    check("full5_seen_not_ready", {31'd0, seen_nr}, 32'd1);
    foreach (glog1[k]) if (glog1[k][31:16] == 16'd5) got5.push_back(glog1[k]);
    check("full5_count", 32'(got5.size()), 32'(acc5.size()));
    for (int k = 0; k < acc5.size() && k < got5.size(); k++)
      check($sformatf("full5_seq%0d", k), got5[k], acc5[k]);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
            12'($urandom) & 12'($urandom), 32'd0);
      for (int i = 0; i < NS; i++) din[i].data = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
